secded_decoder_engine: RTL and testbench



---
 rtl/secded_decoder_engine.sv | 167 ++++++++++++++++
 tb/tb_secded_decoder_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/secded_decoder_engine.sv
// Hamming(16,11) SECDED decoder: reads encoded words from byte memory, corrects
// single errors, flags double errors, writes payload plus flag back to memory.
module secded_decoder_engine #(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 60,
  parameter int AW       = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [7:0]    err1_count,
  output logic [7:0]    err2_count
);

  // state  | meaning
  // IDLE   | waiting for start, done holds result of last job
  // RD_LO  | read strobe for low byte of word idx
  // RD_HI  | read strobe for high byte, low byte arrives
  // CAP    | high byte arrives
  // DEC    | syndrome decode, counters update
  // WR_LO  | write low payload byte
  // WR_HI  | write flag/high payload byte, advance or finish
  // FIN    | raise done
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] CAP   = 3'd3;
  localparam logic [2:0] DEC   = 3'd4;
  localparam logic [2:0] WR_LO = 3'd5;
  localparam logic [2:0] WR_HI = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam int IW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_MSGS - 1);

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_inc;
  logic [7:0]    w_lo;
  logic [7:0]    w_hi;
  logic [7:0]    out_hi;

  logic [15:0]   w;
  logic [15:0]   wc;
  logic [3:0]    syn;
  logic          par;
  logic [1:0]    flag;
  logic [7:0]    dlo;
  logic [7:0]    dhi;
  logic [AW-1:0] src_a;
  logic [AW-1:0] dst_a;
  logic [AW-1:0] src_nxt;

  assign busy = (state != IDLE);

  always_comb begin
    w      = {w_hi, w_lo};
    syn[3] = ^w[15:8];
    syn[2] = ^{w[15:12], w[7:4]};
    syn[1] = ^{w[15:14], w[11:10], w[7:6], w[3:2]};
    syn[0] = ^{w[15], w[13], w[11], w[9], w[7], w[5], w[3], w[1]};
    par    = ^w;
    wc     = w;
    flag   = 2'b00;
    // odd overall parity means a single flip at position syn (syn==0 is p0)
    if (par) begin
      wc   = w ^ (16'd1 << syn);
      flag = 2'b01;
    end else if (syn != 4'd0) begin
      flag = 2'b10;
    end
    dlo = {wc[12:9], wc[7:5], wc[3]};
    dhi = {flag, 3'b000, wc[15:13]};
  end

  always_comb begin
    idx_inc = idx + IW'(1);
    src_a   = AW'(SRC_BASE) + AW'({idx, 1'b0});
    dst_a   = AW'(DST_BASE) + AW'({idx, 1'b0});
    src_nxt = AW'(SRC_BASE) + AW'({idx_inc, 1'b0});
  end

  // memory strobes are registered from the next-state decision so they line
  // up with the state that owns them and hold the address between accesses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'h00;
      err1_count  <= 8'h00;
      err2_count  <= 8'h00;
      w_lo        <= 8'h00;
      w_hi        <= 8'h00;
      out_hi      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            err1_count <= 8'h00;
            err2_count <= 8'h00;
            done       <= 1'b0;
            mem_rd_en  <= 1'b1;
            mem_addr   <= AW'(SRC_BASE);
            state      <= RD_LO;
          end
        end
        RD_LO: begin
          mem_addr <= src_a + AW'(1);
          state    <= RD_HI;
        end
        RD_HI: begin
          w_lo      <= mem_rd_data;
          mem_rd_en <= 1'b0;
          state     <= CAP;
        end
        CAP: begin
          w_hi  <= mem_rd_data;
          state <= DEC;
        end
        DEC: begin
          out_hi <= dhi;
          if (flag == 2'b01 && err1_count != 8'hFF) err1_count <= err1_count + 8'd1;
          if (flag == 2'b10 && err2_count != 8'hFF) err2_count <= err2_count + 8'd1;
          mem_wr_en   <= 1'b1;
          mem_addr    <= dst_a;
          mem_wr_data <= dlo;
          state       <= WR_LO;
        end
        WR_LO: begin
          mem_addr    <= dst_a + AW'(1);
          mem_wr_data <= out_hi;
          state       <= WR_HI;
        end
        WR_HI: begin
          mem_wr_en <= 1'b0;
          if (idx == LAST) begin
            state <= FIN;
          end else begin
            idx       <= idx_inc;
            mem_rd_en <= 1'b1;
            mem_addr  <= src_nxt;
            state     <= RD_LO;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_decoder_engine.sv
// Directed bench for secded_decoder_engine with a byte-wide synchronous memory model.
module tb_secded_decoder_engine;
  localparam int N   = 15;
  localparam int SRC = 30;
  localparam int DST = 60;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       done, busy, mem_rd_en, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, err1_count, err2_count;
  logic [7:0] mem_rd_data = 8'h00;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = 8'h00;
  logic [7:0] tb_wd = 8'h00;
  int         wr_cnt = 0;
  logic       overlap = 1'b0;

  logic [15:0] enc [N];
  logic [7:0]  exp_lo [N];
  logic [7:0]  exp_hi [N];
  int          exp_e1, exp_e2;
  int          n_cmp = 0;
  int          n_bad = 0;

  secded_decoder_engine dut (
    .clock(clock), .reset_n(reset_n), .start(start), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .err1_count(err1_count), .err2_count(err2_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
    if (mem_rd_en && mem_wr_en) overlap <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc11(input logic [10:0] d);
    logic [15:0] w;
    w = '0;
    w[3] = d[0];
    w[7:5] = d[3:1];
    w[15:9] = d[10:4];
    w[1] = ^{w[3], w[5], w[7], w[9], w[11], w[13], w[15]};
    w[2] = ^{w[3], w[6], w[7], w[10], w[11], w[14], w[15]};
    w[4] = ^{w[7:5], w[15:12]};
    w[8] = ^w[15:9];
    w[0] = ^w[15:1];
    return w;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic load_job();
    for (int i = 0; i < N; i++) begin
      poke(8'(SRC + 2*i), enc[i][7:0]);
      poke(8'(SRC + 2*i + 1), enc[i][15:8]);
      poke(8'(DST + 2*i), 8'hAA);
      poke(8'(DST + 2*i + 1), 8'hAA);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // mode 1: stray start mid-job; mode 2: raise start during FIN and keep it high
  task automatic wait_done(input int mode, output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
      start = (mode == 1 && cyc == 40) || (mode == 2 && cyc >= 90);
    end
  endtask

  task automatic check_job(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_lo%0d", tag, i), 32'(mem[8'(DST + 2*i)]), 32'(exp_lo[i]));
      chk($sformatf("%s_hi%0d", tag, i), 32'(mem[8'(DST + 2*i + 1)]), 32'(exp_hi[i]));
    end
    chk({tag, "_err1"}, 32'(err1_count), 32'(exp_e1));
    chk({tag, "_err2"}, 32'(err2_count), 32'(exp_e2));
  endtask

  initial begin
    int cyc, k, w0;
    logic [10:0] d;
    logic [15:0] c, w;
    int p, q;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_err1", 32'(err1_count), 0);
    chk("rst_err2", 32'(err2_count), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // job 1: hand-computed directed words, rest clean
    enc[0] = 16'h000F; exp_lo[0] = 8'h01; exp_hi[0] = 8'h00;
    enc[1] = 16'h020F; exp_lo[1] = 8'h01; exp_hi[1] = 8'h40;
    enc[2] = 16'h000E; exp_lo[2] = 8'h01; exp_hi[2] = 8'h40;
    enc[3] = 16'h0207; exp_lo[3] = 8'h10; exp_hi[3] = 8'h80;
    for (int i = 4; i < N; i++) begin
      d = 11'(i * 173 + 5);
      enc[i] = enc11(d);
      exp_lo[i] = d[7:0];
      exp_hi[i] = {5'b00000, d[10:8]};
    end
    exp_e1 = 2; exp_e2 = 1;
    load_job();
    pulse_start();
    chk("j1_busy", 32'(busy), 1);
    wait_done(0, cyc);
    chk("j1_cycles", 32'(cyc), 91);
    chk("j1_busy_after", 32'(busy), 0);
    check_job("j1");

    // job 2: random payloads, single errors except every fourth word (double)
    exp_e1 = 0; exp_e2 = 0;
    for (int i = 0; i < N; i++) begin
      d = 11'($urandom_range(0, 2047));
      c = enc11(d);
      p = $urandom_range(0, 15);
      if (i % 4 == 3) begin
        q = (p + $urandom_range(1, 15)) % 16;
        w = c ^ (16'd1 << p) ^ (16'd1 << q);
        exp_lo[i] = {w[12:9], w[7:5], w[3]};
        exp_hi[i] = {2'b10, 3'b000, w[15:13]};
        exp_e2++;
      end else begin
        w = c ^ (16'd1 << p);
        exp_lo[i] = d[7:0];
        exp_hi[i] = {2'b01, 3'b000, d[10:8]};
        exp_e1++;
      end
      enc[i] = w;
    end
    load_job();
    pulse_start();
    chk("j2_done_clr", 32'(done), 0);
    wait_done(1, cyc);
    chk("j2_cycles", 32'(cyc), 91);
    check_job("j2");

    // start during FIN ignored, start in the following IDLE cycle accepted
    load_job();
    pulse_start();
    wait_done(2, cyc);
    chk("fin_cycles", 32'(cyc), 91);
    chk("fin_start_ignored", 32'(done), 1);
    @(posedge clock);
    #1 start = 1'b0;
    chk("idle_start_done", 32'(done), 0);
    chk("idle_start_busy", 32'(busy), 1);
    wait_done(0, cyc);
    chk("restart_cycles", 32'(cyc), 91);
    check_job("j3");

    // reset in WR_LO of word 7
    load_job();
    pulse_start();
    k = 0;
    while (!(mem_wr_en && mem_addr == 8'(DST + 14)) && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("wrlo7_found", 32'(k < 200), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(mem_wr_en), 0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_wdata", 32'(mem_wr_data), 0);
    chk("mid_rst_err1", 32'(err1_count), 0);
    chk("mid_rst_err2", 32'(err2_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    w0 = wr_cnt;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("post_rst_writes", 32'(wr_cnt - w0), 0);
    chk("post_rst_w7lo", 32'(mem[8'(DST + 14)]), 32'h AA);
    chk("post_rst_done", 32'(done), 0);
    load_job();
    pulse_start();
    wait_done(0, cyc);
    chk("j4_cycles", 32'(cyc), 91);
    check_job("j4");
    chk("rd_wr_overlap", 32'(overlap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
